// File: rtl/mult4_seq_ctrl.sv
// Sequencing controller for the WIDTH-bit shift-and-add multiplier: latches Q/R on a
// START rising edge, forms P one multiplier bit per clock and holds Q, R, P for display.
module mult4_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               CLR,
  input  logic [WIDTH-1:0]   Q_IN,
  input  logic [WIDTH-1:0]   R_IN,
  output logic               BUSY,
  output logic               DONE,
  output logic               P_VALID,
  output logic [WIDTH-1:0]   Q_OUT,
  output logic [WIDTH-1:0]   R_OUT,
  output logic [2*WIDTH-1:0] P_OUT
);

  localparam int P_W   = 2 * WIDTH;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             start_prev_q, start_prev_d;
  logic [WIDTH-1:0] md_q, md_d;
  logic [WIDTH-1:0] mr_q, mr_d;
  logic [P_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_out_q, q_out_d;
  logic [WIDTH-1:0] r_out_q, r_out_d;
  logic [P_W-1:0]   p_out_q, p_out_d;
  logic             p_valid_q, p_valid_d;
  logic             start_edge;

  function automatic logic [P_W-1:0] partial_prod(input logic [WIDTH-1:0] md,
                                                  input logic             bit0,
                                                  input logic [CNT_W-1:0] sh);
    logic [P_W-1:0] ext;
    ext = {{WIDTH{1'b0}}, md};
    return bit0 ? (ext << sh) : '0;
  endfunction

  // start_prev resets high so a START held through reset release is not an edge
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b1;
      md_q         <= '0;
      mr_q         <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      q_out_q      <= '0;
      r_out_q      <= '0;
      p_out_q      <= '0;
      p_valid_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      md_q         <= md_d;
      mr_q         <= mr_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      q_out_q      <= q_out_d;
      r_out_q      <= r_out_d;
      p_out_q      <= p_out_d;
      p_valid_q    <= p_valid_d;
    end
  end

  assign start_edge = START & ~start_prev_q;

  always_comb begin
    state_d      = state_q;
    start_prev_d = START;
    md_d         = md_q;
    mr_d         = mr_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    q_out_d      = q_out_q;
    r_out_d      = r_out_q;
    p_out_d      = p_out_q;
    p_valid_d    = p_valid_q;

    if (CLR) begin
      state_d   = S_IDLE;
      acc_d     = '0;
      cnt_d     = '0;
      q_out_d   = '0;
      r_out_d   = '0;
      p_out_d   = '0;
      p_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (start_edge) state_d = S_LOAD;
        S_LOAD: begin
          q_out_d   = Q_IN;
          r_out_d   = R_IN;
          md_d      = Q_IN;
          mr_d      = R_IN;
          acc_d     = '0;
          cnt_d     = '0;
          p_valid_d = 1'b0;
          state_d   = S_CALC;
        end
        S_CALC: begin
          acc_d = acc_q + partial_prod(md_q, mr_q[0], cnt_q);
          mr_d  = mr_q >> 1;
          cnt_d = cnt_q + 1'b1;
          // P_OUT only moves here, so the display never shows a partial sum
          if (cnt_q == CNT_LAST) begin
            p_out_d   = acc_d;
            p_valid_d = 1'b1;
            state_d   = S_DONE;
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign BUSY    = (state_q == S_LOAD) | (state_q == S_CALC);
  assign DONE    = (state_q == S_DONE);
  assign P_VALID = p_valid_q;
  assign Q_OUT   = q_out_q;
  assign R_OUT   = r_out_q;
  assign P_OUT   = p_out_q;

endmodule

// File: tb/tb_mult4_seq_ctrl.sv
// Randomized and directed bench for mult4_seq_ctrl against a cycle-count reference model.
module tb_mult4_seq_ctrl;

  localparam int WIDTH = 4;

  logic               CLK = 1'b0;
  logic               RST, START, CLR;
  logic [WIDTH-1:0]   Q_IN, R_IN;
  logic               BUSY, DONE, P_VALID;
  logic [WIDTH-1:0]   Q_OUT, R_OUT;
  logic [2*WIDTH-1:0] P_OUT;

  mult4_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .RST(RST), .START(START), .CLR(CLR), .Q_IN(Q_IN), .R_IN(R_IN),
    .BUSY(BUSY), .DONE(DONE), .P_VALID(P_VALID), .Q_OUT(Q_OUT), .R_OUT(R_OUT),
    .P_OUT(P_OUT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  // Model: ph=0 idle, 1 load, 2..WIDTH+1 calc, WIDTH+2 done
  int                 ph;
  logic [WIDTH-1:0]   m_q, m_r;
  logic [2*WIDTH-1:0] m_p;
  logic               m_pv, m_prev;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ph = 0; m_q = '0; m_r = '0; m_p = '0; m_pv = 1'b0; m_prev = 1'b1;
  endtask

  task automatic model_step();
    if (CLR) begin
      ph = 0; m_q = '0; m_r = '0; m_p = '0; m_pv = 1'b0;
    end else if (ph == 0) begin
      if (START && !m_prev) ph = 1;
    end else if (ph == 1) begin
      m_q = Q_IN; m_r = R_IN; m_pv = 1'b0; ph = 2;
    end else if (ph <= WIDTH) begin
      ph++;
    end else if (ph == WIDTH + 1) begin
      m_p = (2*WIDTH)'(int'(m_q) * int'(m_r));
      m_pv = 1'b1;
      ph = WIDTH + 2;
    end else begin
      ph = 0;
    end
    m_prev = START;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".busy"},  32'(BUSY),    32'(ph >= 1 && ph <= WIDTH + 1));
    check_eq({tag, ".done"},  32'(DONE),    32'(ph == WIDTH + 2));
    check_eq({tag, ".pval"},  32'(P_VALID), 32'(m_pv));
    check_eq({tag, ".q_out"}, 32'(Q_OUT),   32'(m_q));
    check_eq({tag, ".r_out"}, 32'(R_OUT),   32'(m_r));
    check_eq({tag, ".p_out"}, 32'(P_OUT),   32'(m_p));
    if (DONE) done_cnt++;
  endtask

  task automatic cyc(input logic st, input logic cl, input logic [WIDTH-1:0] q,
                     input logic [WIDTH-1:0] r);
    @(negedge CLK);
    START = st; CLR = cl; Q_IN = q; R_IN = r;
    @(posedge CLK);
    model_step();
    #1 check_outputs("cyc");
  endtask

  task automatic run(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r);
    cyc(1'b0, 1'b0, q, r);
    cyc(1'b1, 1'b0, q, r);
    repeat (WIDTH + 3) cyc(1'b0, 1'b0, q, r);
  endtask

  initial begin
    int busy_n, dn, done_at, d0;
    logic st;

    RST = 1'b1; START = 1'b1; CLR = 1'b0; Q_IN = '0; R_IN = '0;
    model_reset();
    repeat (2) @(negedge CLK);
    check_outputs("reset");
    @(negedge CLK);
    RST = 1'b0;

    // Test 1: 15*15 latency and hold
    cyc(1'b0, 1'b0, 4'd15, 4'd15);
    cyc(1'b1, 1'b0, 4'd15, 4'd15);
    busy_n = BUSY ? 1 : 0; dn = 0; done_at = -1;
    for (int i = 1; i <= 7; i++) begin
      cyc(1'b0, 1'b0, 4'd15, 4'd15);
      if (BUSY) busy_n++;
      if (DONE) begin dn++; done_at = i; end
    end
    check_eq("t1_busy_cycles", 32'(busy_n), 32'd5);
    check_eq("t1_done_pulses", 32'(dn), 32'd1);
    check_eq("t1_done_at", 32'(done_at), 32'(WIDTH + 1));
    check_eq("t1_p", 32'(P_OUT), 32'd225);
    check_eq("t1_pval", 32'(P_VALID), 32'd1);
    check_eq("t1_q", 32'(Q_OUT), 32'd15);
    check_eq("t1_r", 32'(R_OUT), 32'd15);

    // Test 2: zero operands and 13*11
    d0 = done_cnt;
    run(4'd0, 4'd9);
    check_eq("t2_p0", 32'(P_OUT), 32'd0);
    run(4'd9, 4'd0);
    check_eq("t2_p1", 32'(P_OUT), 32'd0);
    run(4'd13, 4'd11);
    check_eq("t2_p2", 32'(P_OUT), 32'd143);
    check_eq("t2_dones", 32'(done_cnt - d0), 32'd3);

    // Test 3: held START gives one run; a fresh edge gives another
    cyc(1'b0, 1'b0, 4'd7, 4'd6);
    d0 = done_cnt;
    repeat (20) cyc(1'b1, 1'b0, 4'd7, 4'd6);
    check_eq("t3_one_done", 32'(done_cnt - d0), 32'd1);
    check_eq("t3_p", 32'(P_OUT), 32'd42);
    run(4'd7, 4'd6);
    check_eq("t3_second_run", 32'(done_cnt - d0), 32'd2);

    // Test 4: operand change and START pulse during CALC
    d0 = done_cnt;
    cyc(1'b0, 1'b0, 4'd3, 4'd5);
    cyc(1'b1, 1'b0, 4'd3, 4'd5);
    cyc(1'b0, 1'b0, 4'd3, 4'd5);
    cyc(1'b0, 1'b0, 4'd12, 4'd5);
    cyc(1'b1, 1'b0, 4'd12, 4'd5);
    cyc(1'b0, 1'b0, 4'd12, 4'd5);
    repeat (6) cyc(1'b0, 1'b0, 4'd12, 4'd5);
    check_eq("t4_p", 32'(P_OUT), 32'd15);
    check_eq("t4_q", 32'(Q_OUT), 32'd3);
    check_eq("t4_one_done", 32'(done_cnt - d0), 32'd1);
    check_eq("t4_idle", 32'(BUSY), 32'd0);

    // Test 5: asynchronous reset in the second CALC cycle
    run(4'd7, 4'd6);
    check_eq("t5_pre_p", 32'(P_OUT), 32'd42);
    cyc(1'b0, 1'b0, 4'd2, 4'd2);
    cyc(1'b1, 1'b0, 4'd2, 4'd2);
    cyc(1'b1, 1'b0, 4'd2, 4'd2);
    cyc(1'b1, 1'b0, 4'd2, 4'd2);
    d0 = done_cnt;
    @(negedge CLK);
    RST = 1'b1;
    #1;
    model_reset();
    check_outputs("t5_rst");
    check_eq("t5_p_zero", 32'(P_OUT), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (10) cyc(1'b1, 1'b0, 4'd2, 4'd2);
    check_eq("t5_no_done", 32'(done_cnt - d0), 32'd0);
    check_eq("t5_no_busy", 32'(BUSY), 32'd0);

    // Test 6: CLR with START edge, then CLR mid-CALC
    run(4'd13, 4'd11);
    check_eq("t6_pre_p", 32'(P_OUT), 32'd143);
    d0 = done_cnt;
    cyc(1'b0, 1'b0, 4'd13, 4'd11);
    cyc(1'b1, 1'b1, 4'd13, 4'd11);
    check_eq("t6_clr_p", 32'(P_OUT), 32'd0);
    repeat (8) cyc(1'b1, 1'b0, 4'd13, 4'd11);
    check_eq("t6_no_run", 32'(done_cnt - d0), 32'd0);
    cyc(1'b0, 1'b0, 4'd5, 4'd5);
    cyc(1'b1, 1'b0, 4'd5, 4'd5);
    cyc(1'b0, 1'b0, 4'd5, 4'd5);
    cyc(1'b0, 1'b0, 4'd5, 4'd5);
    cyc(1'b0, 1'b1, 4'd5, 4'd5);
    check_eq("t6_clr_busy", 32'(BUSY), 32'd0);
    repeat (8) cyc(1'b0, 1'b0, 4'd5, 4'd5);
    check_eq("t6_no_done", 32'(done_cnt - d0), 32'd0);

    // Randomized traffic
    d0 = done_cnt;
    for (int i = 0; i < 1500; i++) begin
      st = START ^ ($urandom_range(0, 2) == 0);
      cyc(st, ($urandom_range(0, 59) == 0), WIDTH'($urandom), WIDTH'($urandom));
    end
    check_eq("rand_some_runs", 32'(done_cnt - d0 > 20), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
